// File: rtl/comparator_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among NREQ requesters.
// Define CMP_ARB_SIGNED_EN to compare operands as two's complement.
module comparator_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_gt,
  output logic                  rsp_lt,
  output logic                  rsp_eq
);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    RESP
  } state_t;

`ifdef CMP_ARB_SIGNED_EN
  // Flipping the sign bit maps two's complement onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_FLIP = {1'b1, {(WIDTH-1){1'b0}}};
`else
  localparam logic [WIDTH-1:0] MSB_FLIP = '0;
`endif

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;
  logic             grant;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  function automatic logic [1:0] cmp_f(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic gt;
    logic lt;
    logic done;
    gt   = 1'b0;
    lt   = 1'b0;
    done = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!done && (a[i] != b[i])) begin
        gt   = a[i];
        lt   = b[i];
        done = 1'b1;
      end
    end
    return {gt, lt};
  endfunction

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // A grant only happens when the result slot is free or draining now.
  assign grant = !rst && gnt_vld &&
                 ((state_q == IDLE) ||
                  ((state_q == RESP) && rsp_ready));

  assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gid_d    = gid_q;
    a_d      = a_q;
    b_d      = b_q;
    rsp_id_d = rsp_id_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    if (grant) begin
      rr_ptr_d = gnt_idx;
      gid_d    = gnt_idx;
      a_d      = a_arr[gnt_idx];
      b_d      = b_arr[gnt_idx];
    end
    unique case (state_q)
      IDLE: begin
        if (grant) state_d = CMP;
      end
      CMP: begin
        {gt_d, lt_d} = cmp_f(a_q ^ MSB_FLIP, b_q ^ MSB_FLIP);
        eq_d         = (a_q == b_q);
        rsp_id_d     = gid_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = grant ? CMP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDW'(NREQ - 1);
      gid_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rsp_id_q <= '0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rsp_id_q <= rsp_id_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_gt    = rsp_valid & gt_q;
  assign rsp_lt    = rsp_valid & lt_q;
  assign rsp_eq    = rsp_valid & eq_q;

endmodule
